// File: rtl/mux_pipeline_arbiter.sv
// mux_pipeline_arbiter: packet arbiter that holds sel per packet and drains a pipelined mux before switching owners.
// Define MUX_PIPELINE_ARBITER_PRIORITY_EN for fixed priority (highest index wins) instead of round-robin.
module mux_pipeline_arbiter #(
  parameter int INPUT_COUNT = 4,
  parameter int LATENCY = 2,
  parameter int IDX_W = $clog2(INPUT_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INPUT_COUNT-1:0] req,
  input  logic [INPUT_COUNT-1:0] last,
  output logic [INPUT_COUNT-1:0] grant,
  output logic [IDX_W-1:0]       sel,
  output logic                   beat,
  output logic                   out_valid,
  output logic [IDX_W-1:0]       out_index,
  output logic                   busy
);
  localparam int CNT_W = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [INPUT_COUNT-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] sel_q, sel_d, ptr_q, ptr_d, win, idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pkt_end, arb, inflight;
  assign grant = grant_q;
  assign sel = sel_q;
  assign beat = |(req & grant_q);
  assign busy = (state_q != IDLE) || inflight;
  always_comb begin
    win = '0;
    idx = '0;
`ifdef MUX_PIPELINE_ARBITER_PRIORITY_EN
    for (int i = 0; i < INPUT_COUNT; i++) begin
      idx = IDX_W'(i);
      if (req[idx]) win = idx;
    end
`else
    // Scan from the pointer downward so the slot right after rr_ptr is written last and wins.
    for (int i = INPUT_COUNT; i >= 1; i--) begin
      idx = IDX_W'((int'(ptr_q) + i) % INPUT_COUNT);
      if (req[idx]) win = idx;
    end
`endif
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    pkt_end = beat && last[sel_q];
    // The last drain cycle arbitrates directly so the new grant lands LATENCY+1 cycles after the final beat.
    arb = (state_q == IDLE) || (state_q == DRAIN && cnt_q == '0) ||
          (pkt_end && (LATENCY == 0 || win == sel_q));
    if (arb) begin
      state_d = |req ? OWN : IDLE;
      grant_d = |req ? INPUT_COUNT'(1) << win : '0;
      sel_d = |req ? win : sel_q;
      ptr_d = |req ? win : ptr_q;
    end else if (pkt_end) begin
      state_d = DRAIN;
      grant_d = '0;
      cnt_d = CNT_W'(LATENCY - 1);
    end else if (state_q == DRAIN) begin
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q <= '0;
      ptr_q <= IDX_W'(INPUT_COUNT - 1);
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  generate
    if (LATENCY == 0) begin : g_comb
      assign out_valid = beat;
      assign out_index = sel_q;
      assign inflight = 1'b0;
    end else begin : g_pipe
      logic [LATENCY-1:0] v_q;
      logic [IDX_W-1:0] idx_q [LATENCY];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_q <= '0;
          for (int k = 0; k < LATENCY; k++) idx_q[k] <= '0;
        end else begin
          v_q[0] <= beat;
          idx_q[0] <= sel_q;
          for (int k = 1; k < LATENCY; k++) begin
            v_q[k] <= v_q[k-1];
            idx_q[k] <= idx_q[k-1];
          end
        end
      end
      assign out_valid = v_q[LATENCY-1];
      assign out_index = idx_q[LATENCY-1];
      assign inflight = |v_q;
    end
  endgenerate
endmodule

// File: tb/tb_mux_pipeline_arbiter.sv
// tb_mux_pipeline_arbiter: directed cycle vectors for LATENCY=2 and LATENCY=0 instances.
module tb_mux_pipeline_arbiter;
  typedef struct {
    logic       rn;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       beat;
    logic       ov;
    logic [1:0] oi;
    logic       busy;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst2_n, rst0_n;
  logic [3:0] req2, last2, req0, last0, grant2, grant0;
  logic [1:0] sel2, sel0, oi2, oi0;
  logic beat2, beat0, ov2, ov0, busy2, busy0;
  int n_chk = 0;
  int n_fail = 0;
  vec_t t2[$];
  vec_t t0[$];
  mux_pipeline_arbiter #(.INPUT_COUNT(4), .LATENCY(2)) d2 (
    .clk(clk), .rst_n(rst2_n), .req(req2), .last(last2), .grant(grant2), .sel(sel2),
    .beat(beat2), .out_valid(ov2), .out_index(oi2), .busy(busy2));
  mux_pipeline_arbiter #(.INPUT_COUNT(4), .LATENCY(0)) d0 (
    .clk(clk), .rst_n(rst0_n), .req(req0), .last(last0), .grant(grant0), .sel(sel0),
    .beat(beat0), .out_valid(ov0), .out_index(oi0), .busy(busy0));
  function automatic vec_t mk(input int rn, rq, ls, g, s, b, ov, oi, bz);
    vec_t v;
    v.rn = 1'(rn);
    v.req = 4'(rq);
    v.last = 4'(ls);
    v.grant = 4'(g);
    v.sel = 2'(s);
    v.beat = 1'(b);
    v.ov = 1'(ov);
    v.oi = 2'(oi);
    v.busy = 1'(bz);
    return v;
  endfunction
  task automatic chk(input string nm, input int i, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, i, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input int i, input bit z);
    if (z) begin
      rst0_n = v.rn; req0 = v.req; last0 = v.last;
    end else begin
      rst2_n = v.rn; req2 = v.req; last2 = v.last;
    end
    @(negedge clk);
    chk(z ? "L0 grant" : "L2 grant", i, z ? grant0 : grant2, v.grant);
    chk(z ? "L0 sel" : "L2 sel", i, {2'b00, z ? sel0 : sel2}, {2'b00, v.sel});
    chk(z ? "L0 beat" : "L2 beat", i, {3'b000, z ? beat0 : beat2}, {3'b000, v.beat});
    chk(z ? "L0 out_valid" : "L2 out_valid", i, {3'b000, z ? ov0 : ov2}, {3'b000, v.ov});
    chk(z ? "L0 busy" : "L2 busy", i, {3'b000, z ? busy0 : busy2}, {3'b000, v.busy});
    if (v.ov) chk(z ? "L0 out_index" : "L2 out_index", i, {2'b00, z ? oi0 : oi2}, {2'b00, v.oi});
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst2_n = 1'b0; rst0_n = 1'b0;
    req2 = '0; last2 = '0; req0 = '0; last0 = '0;
    // rn, req, last | grant, sel, beat, out_valid, out_index, busy
    t2.push_back(mk(1, 'h2, 'h0, 'h0, 0, 0, 0, 0, 0));
    t2.push_back(mk(1, 'h2, 'h0, 'h2, 1, 1, 0, 0, 1));
    t2.push_back(mk(1, 'h2, 'h0, 'h2, 1, 1, 0, 0, 1));
    t2.push_back(mk(1, 'h2, 'h2, 'h2, 1, 1, 1, 1, 1));
    t2.push_back(mk(1, 'h0, 'h0, 'h2, 1, 0, 1, 1, 1));
    t2.push_back(mk(1, 'h0, 'h0, 'h2, 1, 0, 1, 1, 1));
    t2.push_back(mk(1, 'h2, 'h0, 'h2, 1, 1, 0, 0, 1));
    t2.push_back(mk(0, 'h2, 'h0, 'h2, 1, 1, 0, 0, 1));
    t2.push_back(mk(1, 'h0, 'h0, 'h0, 0, 0, 0, 0, 0));
    t2.push_back(mk(1, 'h5, 'h5, 'h0, 0, 0, 0, 0, 0));
    t2.push_back(mk(1, 'h5, 'h5, 'h1, 0, 1, 0, 0, 1));
    t2.push_back(mk(1, 'h5, 'h5, 'h0, 0, 0, 0, 0, 1));
    t2.push_back(mk(1, 'h5, 'h5, 'h0, 0, 0, 1, 0, 1));
    t2.push_back(mk(1, 'h5, 'h5, 'h4, 2, 1, 0, 0, 1));
    t2.push_back(mk(1, 'h5, 'h5, 'h0, 2, 0, 0, 0, 1));
    t2.push_back(mk(1, 'h5, 'h5, 'h0, 2, 0, 1, 2, 1));
    t2.push_back(mk(1, 'h5, 'h5, 'h1, 0, 1, 0, 0, 1));
    t2.push_back(mk(1, 'h5, 'h5, 'h0, 0, 0, 0, 0, 1));
    t2.push_back(mk(1, 'h5, 'h5, 'h0, 0, 0, 1, 0, 1));
    t2.push_back(mk(1, 'h5, 'h5, 'h4, 2, 1, 0, 0, 1));
    t2.push_back(mk(1, 'h0, 'h0, 'h0, 2, 0, 0, 0, 1));
    t2.push_back(mk(1, 'h0, 'h0, 'h0, 2, 0, 1, 2, 1));
    t2.push_back(mk(1, 'h0, 'h0, 'h0, 2, 0, 0, 0, 0));
    t2.push_back(mk(1, 'h8, 'h8, 'h0, 2, 0, 0, 0, 0));
    t2.push_back(mk(1, 'h8, 'h8, 'h8, 3, 1, 0, 0, 1));
    t2.push_back(mk(1, 'h8, 'h8, 'h8, 3, 1, 0, 0, 1));
    t2.push_back(mk(1, 'h8, 'h8, 'h8, 3, 1, 1, 3, 1));
    t2.push_back(mk(1, 'h8, 'h8, 'h8, 3, 1, 1, 3, 1));
    t2.push_back(mk(1, 'h8, 'h0, 'h8, 3, 1, 1, 3, 1));
    t2.push_back(mk(1, 'h4, 'h0, 'h8, 3, 0, 1, 3, 1));
    t2.push_back(mk(1, 'h4, 'h4, 'h8, 3, 0, 1, 3, 1));
    t2.push_back(mk(1, 'h4, 'h0, 'h8, 3, 0, 0, 0, 1));
    t2.push_back(mk(1, 'hC, 'h8, 'h8, 3, 1, 0, 0, 1));
    t2.push_back(mk(1, 'h4, 'h0, 'h0, 3, 0, 0, 0, 1));
    t2.push_back(mk(1, 'h4, 'h0, 'h0, 3, 0, 1, 3, 1));
    t2.push_back(mk(1, 'h4, 'h4, 'h4, 2, 1, 0, 0, 1));
    t0.push_back(mk(1, 'h3, 'h0, 'h0, 0, 0, 0, 0, 0));
    t0.push_back(mk(1, 'h3, 'h0, 'h1, 0, 1, 1, 0, 1));
    t0.push_back(mk(1, 'h3, 'h3, 'h1, 0, 1, 1, 0, 1));
    t0.push_back(mk(1, 'h3, 'h0, 'h2, 1, 1, 1, 1, 1));
    t0.push_back(mk(1, 'h3, 'h3, 'h2, 1, 1, 1, 1, 1));
    t0.push_back(mk(1, 'h3, 'h0, 'h1, 0, 1, 1, 0, 1));
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < t2.size(); i++) run(t2[i], i, 1'b0);
    for (int i = 0; i < t0.size(); i++) run(t0[i], i, 1'b1);
    // Abort mid-drain: the in-flight last beat must not appear after reset.
    req2 = 4'h5; last2 = 4'h5; rst2_n = 1'b0;
    @(posedge clk); #1;
    rst2_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req2 = 4'h0; last2 = 4'h0;
    @(negedge clk);
    chk("L2 drain grant", 0, grant2, 4'h0);
    rst2_n = 1'b0;
    @(posedge clk); #1;
    rst2_n = 1'b1;
    @(negedge clk);
    chk("L2 abort out_valid", 0, {3'b000, ov2}, 4'h0);
    chk("L2 abort busy", 0, {3'b000, busy2}, 4'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
